gtfwizard_mac_example_gtfmac_hwchk_bitslip_resp: RTL and testbench
==================================================================

Name: gtfwizard_mac_example_gtfmac_hwchk_bitslip_resp

Overview:
- Synthesizable responder model of the GTFMAC RX bitslip interface, i.e. the GTF side of the bitslip handshake.
- Emulates PCS block-lock hunting by emitting rx_bitslip pulses and emulates the PMA slip handshake (rxslippma/rxslippmardy, one-UI slip and gearbox resync).
- Used in hwchk loopback/self-test builds to exercise the bitslip corrector without a live transceiver.
- Exposes a programmable initial misalignment and reports the net alignment achieved.

Parameters:
- SLIP_GAP, 16: cycles between successive rx_bitslip pulses while hunting (≥3).
- LOCK_DELAY, 64: aligned cycles required before rx_block_lock asserts (≥1).
- ACK_LAT, 4: cycles from bs_slip_pma rise to rx_slip_pma_rdy fall (≥1).
- REL_LAT, 8: cycles from bs_slip_pma fall (rdy low) to rx_slip_pma_rdy rise (≥1).

Ports:
- rx_clk  in  1  sole clock.
- rx_rst_n  in  1  reset, synchronous, active-low.
- ctl_slip_target  in  7  initial misalignment in UI; sampled on the rx_rst_n=0 cycles only.
- bs_gb_seq_sync  in  1  gearbox resync request, level.
- bs_disable_bitslip  in  1  freezes PCS hunting when 1.
- bs_slip_pma  in  1  2-UI PMA slip request.
- bs_slip_one_ui  in  1  1-UI slip request; acts on rising edge.
- rx_block_lock  out  1  emulated block lock.
- rx_bitslip  out  1  one-cycle pulse per PCS slip.
- rx_slip_pma_rdy  out  1  PMA slip ready/ack.
- stat_pcs_slips  out  7  pulses since last reset/resync.
- stat_pma_ui  out  7  UI applied by PMA/one-UI slips since reset.
- stat_overcorrect  out  1  sticky; pma_ui exceeded target.

Behaviour:
- Reset values: rx_block_lock=0, rx_bitslip=0, rx_slip_pma_rdy=1, stat_pcs_slips=0, stat_pma_ui=0, stat_overcorrect=0.
- Reset loads target from ctl_slip_target.
- Reset asserted mid-handshake aborts everything on the next edge.
- residual = target − stat_pma_ui, 7-bit. Arithmetic is saturating, never wrapping: residual is 0 when pma_ui ≥ target.
- PCS FSM (state codes in package):
  - HUNT:
    - If stat_pcs_slips==residual, go to ALIGN with the lock counter cleared.
    - Else, if bs_disable_bitslip=0 and the gap counter reaches SLIP_GAP−1, pulse rx_bitslip for one cycle and increment stat_pcs_slips.
    - bs_disable_bitslip=1 holds the gap counter.
    - First pulse occurs SLIP_GAP cycles after entering HUNT.
  - ALIGN: count cycles; at LOCK_DELAY go to LOCKED and set rx_block_lock=1 on that edge. If bs_disable_bitslip=1, counting continues.
  - LOCKED: rx_block_lock=1; no bitslip pulses.
  - RESYNC:
    - Entered from any state on the rising edge of bs_gb_seq_sync.
    - On entry: rx_block_lock=0 and stat_pcs_slips=0.
    - Stays while bs_gb_seq_sync=1; on release goes to HUNT against the updated residual.
    - residual 0 ⇒ HUNT→ALIGN immediately with no pulses.
- PMA slip handshake (independent FSM PIDLE/PACK/PWAIT/PREL):
  - PIDLE: rdy=1. A bs_slip_pma rising edge goes to PACK.
  - PACK: after ACK_LAT cycles, rdy→0 and stat_pma_ui += 2; go to PWAIT.
  - PWAIT: rdy=0. When bs_slip_pma=0, go to PREL.
  - PREL: after REL_LAT cycles, rdy→1; go to PIDLE.
  - bs_slip_pma held high through PIDLE re-entry does not re-trigger; a new rising edge is required.
- bs_slip_one_ui rising edge: stat_pma_ui += 1.
  - Same cycle as the PMA increment: both apply (+3).
- stat_pma_ui saturates at 127.
- stat_overcorrect sets when stat_pma_ui > target after update; cleared only by reset.
- PMA slips while LOCKED do not drop lock; only a resync re-evaluates alignment.
- Edge detects use one-cycle-registered copies of the inputs. Inputs are synchronous to rx_clk.

Decomposition:
- Shared package holds:
  - PCS state codes: HUNT, ALIGN, LOCKED, RESYNC.
  - PMA state codes: PIDLE, PACK, PWAIT, PREL.
  - Width constant BS_CNT_W=7.
- One sub-module, gtfwizard_mac_example_bitslip_resp_pma: the PMA handshake FSM with its latency counter. It outputs rdy and a one-cycle ui_add[1:0] increment.

Test Plan:
- target=5, disable=0 → 5 rx_bitslip pulses spaced 16 cycles; rx_block_lock rises 64 cycles after the 5th; stat_pcs_slips=5.
- Lock at target=5, then two PMA handshakes, one_ui pulse, gb_seq_sync 8 cycles → each rdy falls 4 cycles after slip_pma rise and rises 8 cycles after slip_pma fall; stat_pma_ui=5; after resync, lock in 64 cycles with zero pulses.
- target=0 → no pulses; lock at cycle 64 after reset release.
- target=6, disable=1 asserted after pulse 3 for 100 cycles → no pulses during hold; pulse 4 arrives 16 cycles after release (gap counter frozen, not reset); lock after pulse 6.
- target=1, three PMA slips → stat_pma_ui=6, stat_overcorrect=1; after resync, residual 0 and lock with no pulses.
- rx_rst_n=0 during PWAIT → next edge: rdy=1, lock=0, all stats 0; the new ctl_slip_target=3 yields 3 pulses.

Source files
------------

// File: rtl/gtfwizard_mac_example_gtfmac_hwchk_bitslip_resp_pkg.sv
// Shared types for the GTFMAC RX bitslip responder model.
// Holds the PCS/PMA state codes and the saturating UI arithmetic helpers.
package gtfwizard_mac_example_gtfmac_hwchk_bitslip_resp_pkg;

    localparam int BS_CNT_W = 7;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2,
        RESYNC = 2'd3
    } pcs_state_t;

    typedef enum logic [1:0] {
        PIDLE = 2'd0,
        PACK  = 2'd1,
        PWAIT = 2'd2,
        PREL  = 2'd3
    } pma_state_t;

    function automatic logic [BS_CNT_W-1:0] sat_sub(
        input logic [BS_CNT_W-1:0] a,
        input logic [BS_CNT_W-1:0] b
    );
        return (b >= a) ? '0 : (a - b);
    endfunction

    function automatic logic [BS_CNT_W-1:0] sat_add(
        input logic [BS_CNT_W-1:0] a,
        input logic [1:0]          b
    );
        logic [BS_CNT_W:0] s;
        s = {1'b0, a} + {{(BS_CNT_W-1){1'b0}}, b};
        return s[BS_CNT_W] ? '1 : s[BS_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/gtfwizard_mac_example_bitslip_resp_pma.sv
// PMA slip handshake responder: ready/ack latency FSM plus one-UI edge detect.
// o_ui_add is a same-cycle increment: bit1 = 2-UI slip applied, bit0 = 1-UI slip.
module gtfwizard_mac_example_bitslip_resp_pma
    import gtfwizard_mac_example_gtfmac_hwchk_bitslip_resp_pkg::*;
#(
    parameter int ACK_LAT = 4,
    parameter int REL_LAT = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_slip_pma,
    input  logic       i_one_ui,
    output logic       o_rdy,
    output logic [1:0] o_ui_add
);

    localparam logic ACK1 = (ACK_LAT == 1);
    localparam logic REL1 = (REL_LAT == 1);

    pma_state_t  r_state;
    logic [15:0] r_cnt;
    logic        r_rdy;
    logic        r_slip_q;
    logic        r_one_q;

    logic w_slip_rise;
    logic w_one_rise;
    logic w_ack_done;
    logic w_rel_done;

    assign w_slip_rise = i_slip_pma & ~r_slip_q;
    assign w_one_rise  = i_one_ui & ~r_one_q;

    // Latency counts from the cycle the request edge is seen, so the
    // output moves ACK_LAT/REL_LAT cycles after the input transition.
    assign w_ack_done = ((r_state == PIDLE) && w_slip_rise && ACK1) ||
                        ((r_state == PACK) && (r_cnt == 16'(ACK_LAT - 2)));
    assign w_rel_done = ((r_state == PWAIT) && !i_slip_pma && REL1) ||
                        ((r_state == PREL) && (r_cnt == 16'(REL_LAT - 2)));

    assign o_rdy    = r_rdy;
    assign o_ui_add = {w_ack_done, w_one_rise};

    always_ff @(posedge i_clk) begin
        r_slip_q <= i_slip_pma;
        r_one_q  <= i_one_ui;
        if (!i_rst_n) begin
            r_state <= PIDLE;
            r_cnt   <= '0;
            r_rdy   <= 1'b1;
        end else begin
            unique case (r_state)
                PIDLE: begin
                    if (w_slip_rise) begin
                        r_cnt <= '0;
                        if (w_ack_done) begin
                            r_state <= PWAIT;
                            r_rdy   <= 1'b0;
                        end else begin
                            r_state <= PACK;
                        end
                    end
                end
                PACK: begin
                    if (w_ack_done) begin
                        r_state <= PWAIT;
                        r_rdy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                PWAIT: begin
                    if (!i_slip_pma) begin
                        r_cnt <= '0;
                        if (w_rel_done) begin
                            r_state <= PIDLE;
                            r_rdy   <= 1'b1;
                        end else begin
                            r_state <= PREL;
                        end
                    end
                end
                PREL: begin
                    if (w_rel_done) begin
                        r_state <= PIDLE;
                        r_rdy   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/gtfwizard_mac_example_gtfmac_hwchk_bitslip_resp.sv
// GTF-side bitslip responder: emulated PCS block-lock hunt and PMA slip handshake.
// Lets the hwchk bitslip corrector be exercised without a live transceiver.
module gtfwizard_mac_example_gtfmac_hwchk_bitslip_resp
    import gtfwizard_mac_example_gtfmac_hwchk_bitslip_resp_pkg::*;
#(
    parameter int SLIP_GAP   = 16,
    parameter int LOCK_DELAY = 64,
    parameter int ACK_LAT    = 4,
    parameter int REL_LAT    = 8
) (
    input  logic                rx_clk,
    input  logic                rx_rst_n,
    input  logic [BS_CNT_W-1:0] ctl_slip_target,
    input  logic                bs_gb_seq_sync,
    input  logic                bs_disable_bitslip,
    input  logic                bs_slip_pma,
    input  logic                bs_slip_one_ui,
    output logic                rx_block_lock,
    output logic                rx_bitslip,
    output logic                rx_slip_pma_rdy,
    output logic [BS_CNT_W-1:0] stat_pcs_slips,
    output logic [BS_CNT_W-1:0] stat_pma_ui,
    output logic                stat_overcorrect
);

    pcs_state_t          r_state;
    logic [BS_CNT_W-1:0] r_target;
    logic [BS_CNT_W-1:0] r_slips;
    logic [BS_CNT_W-1:0] r_pma_ui;
    logic                r_over;
    logic                r_lock;
    logic                r_bitslip;
    logic [15:0]         r_gap;
    logic [15:0]         r_lock_cnt;
    logic                r_gb_q;

    logic [1:0]          w_ui_add;
    logic [BS_CNT_W-1:0] w_ui_next;
    logic [BS_CNT_W-1:0] w_residual;
    logic                w_gb_rise;
    logic                w_gap_done;
    logic                w_lock_done;

    gtfwizard_mac_example_bitslip_resp_pma #(
        .ACK_LAT (ACK_LAT),
        .REL_LAT (REL_LAT)
    ) u_pma (
        .i_clk      (rx_clk),
        .i_rst_n    (rx_rst_n),
        .i_slip_pma (bs_slip_pma),
        .i_one_ui   (bs_slip_one_ui),
        .o_rdy      (rx_slip_pma_rdy),
        .o_ui_add   (w_ui_add)
    );

    assign w_ui_next   = sat_add(r_pma_ui, w_ui_add);
    assign w_residual  = sat_sub(r_target, r_pma_ui);
    assign w_gb_rise   = bs_gb_seq_sync & ~r_gb_q;
    assign w_gap_done  = (r_gap == 16'(SLIP_GAP - 1));
    // Entry cycle counts as the first aligned cycle.
    assign w_lock_done = ((32'(r_lock_cnt) + 32'd2) >= 32'(LOCK_DELAY));

    assign rx_block_lock    = r_lock;
    assign rx_bitslip       = r_bitslip;
    assign stat_pcs_slips   = r_slips;
    assign stat_pma_ui      = r_pma_ui;
    assign stat_overcorrect = r_over;

    always_ff @(posedge rx_clk) begin
        r_gb_q <= bs_gb_seq_sync;
        if (!rx_rst_n) begin
            r_state    <= HUNT;
            r_target   <= ctl_slip_target;
            r_slips    <= '0;
            r_pma_ui   <= '0;
            r_over     <= 1'b0;
            r_lock     <= 1'b0;
            r_bitslip  <= 1'b0;
            r_gap      <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_bitslip <= 1'b0;
            r_pma_ui  <= w_ui_next;
            if (w_ui_next > r_target) begin
                r_over <= 1'b1;
            end
            if (w_gb_rise) begin
                r_state <= RESYNC;
                r_lock  <= 1'b0;
                r_slips <= '0;
                r_gap   <= '0;
            end else begin
                unique case (r_state)
                    HUNT: begin
                        if (r_slips == w_residual) begin
                            r_state    <= ALIGN;
                            r_lock_cnt <= '0;
                        end else if (!bs_disable_bitslip) begin
                            if (w_gap_done) begin
                                r_bitslip <= 1'b1;
                                r_slips   <= r_slips + 1'b1;
                                r_gap     <= '0;
                            end else begin
                                r_gap <= r_gap + 16'd1;
                            end
                        end
                    end
                    ALIGN: begin
                        if (w_lock_done) begin
                            r_state <= LOCKED;
                            r_lock  <= 1'b1;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + 16'd1;
                        end
                    end
                    LOCKED: begin
                        r_lock <= 1'b1;
                    end
                    RESYNC: begin
                        // Release folds the first HUNT evaluation into this cycle.
                        if (!bs_gb_seq_sync) begin
                            r_gap <= '0;
                            if (w_residual == '0) begin
                                r_state    <= ALIGN;
                                r_lock_cnt <= '0;
                            end else begin
                                r_state <= HUNT;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gtfwizard_mac_example_gtfmac_hwchk_bitslip_resp.sv
// Directed bench for the bitslip responder: lock-timing vector table plus
// handshake, hold, overcorrect, resync and mid-handshake reset sequences.
module tb_gtfwizard_mac_example_gtfmac_hwchk_bitslip_resp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] ctl_slip_target = '0;
    logic       gb_sync = 1'b0;
    logic       dis = 1'b0;
    logic       slip_pma = 1'b0;
    logic       one_ui = 1'b0;
    logic       lock;
    logic       bitslip;
    logic       rdy;
    logic [6:0] pcs_slips;
    logic [6:0] pma_ui;
    logic       over;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gtfwizard_mac_example_gtfmac_hwchk_bitslip_resp dut (
        .rx_clk             (clk),
        .rx_rst_n           (rst_n),
        .ctl_slip_target    (ctl_slip_target),
        .bs_gb_seq_sync     (gb_sync),
        .bs_disable_bitslip (dis),
        .bs_slip_pma        (slip_pma),
        .bs_slip_one_ui     (one_ui),
        .rx_block_lock      (lock),
        .rx_bitslip         (bitslip),
        .rx_slip_pma_rdy    (rdy),
        .stat_pcs_slips     (pcs_slips),
        .stat_pma_ui        (pma_ui),
        .stat_overcorrect   (over)
    );

    typedef struct {
        int target;
        int exp_pulses;
        int exp_first;
        int exp_last;
        int exp_lock;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input int t);
        rst_n = 1'b0;
        ctl_slip_target = 7'(t);
        tick();
        tick();
        check("rst_lock", int'(lock), 0);
        check("rst_bitslip", int'(bitslip), 0);
        check("rst_rdy", int'(rdy), 1);
        check("rst_stats", int'(pcs_slips) + int'(pma_ui) + int'(over), 0);
        rst_n = 1'b1;
    endtask

    // Runs until lock (or budget); edges numbered from 1 after the call.
    task automatic run_lock(input int max, output int pulses,
                            output int first, output int last,
                            output int lock_at);
        pulses = 0;
        first = -1;
        last = -1;
        lock_at = -1;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (bitslip) begin
                pulses++;
                if (first < 0) first = k;
                last = k;
            end
            if (lock) begin
                lock_at = k;
                break;
            end
        end
    endtask

    task automatic run_n(input int n, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (bitslip) pulses++;
        end
    endtask

    task automatic pma_slip(output int fall_k, output int rise_k);
        fall_k = -1;
        rise_k = -1;
        slip_pma = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (!rdy) begin
                fall_k = k;
                break;
            end
        end
        tick();
        tick();
        slip_pma = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (rdy) begin
                rise_k = k;
                break;
            end
        end
        tick();
    endtask

    task automatic resync8();
        int p;
        gb_sync = 1'b1;
        run_n(8, p);
        check("resync_pulses", p, 0);
        check("resync_lock", int'(lock), 0);
        check("resync_slips", int'(pcs_slips), 0);
        gb_sync = 1'b0;
    endtask

    initial begin
        int p, f, l, lk, fk, rk;

        vecs[0] = '{0, 0, -1, -1, 64};
        vecs[1] = '{1, 1, 16, 16, 80};
        vecs[2] = '{2, 2, 16, 32, 96};
        vecs[3] = '{5, 5, 16, 80, 144};
        vecs[4] = '{7, 7, 16, 112, 176};

        for (int i = 0; i < 5; i++) begin
            do_reset(vecs[i].target);
            run_lock(400, p, f, l, lk);
            check($sformatf("v%0d_pulses", i), p, vecs[i].exp_pulses);
            check($sformatf("v%0d_first", i), f, vecs[i].exp_first);
            check($sformatf("v%0d_last", i), l, vecs[i].exp_last);
            check($sformatf("v%0d_lock", i), lk, vecs[i].exp_lock);
            check($sformatf("v%0d_slips", i), int'(pcs_slips),
                  vecs[i].exp_pulses);
        end

        // Locked at 5, then PMA handshakes, one-UI slip, resync.
        do_reset(5);
        run_lock(400, p, f, l, lk);
        check("hs_lock", lk, 144);
        pma_slip(fk, rk);
        check("hs1_fall", fk, 4);
        check("hs1_rise", rk, 8);
        check("hs1_ui", int'(pma_ui), 2);
        pma_slip(fk, rk);
        check("hs2_fall", fk, 4);
        check("hs2_rise", rk, 8);
        one_ui = 1'b1;
        tick();
        one_ui = 1'b0;
        tick();
        check("hs_ui", int'(pma_ui), 5);
        check("hs_over", int'(over), 0);
        check("hs_keep_lock", int'(lock), 1);
        resync8();
        run_lock(200, p, f, l, lk);
        check("hs_re_pulses", p, 0);
        check("hs_re_lock", lk, 64);

        // Disable hold after pulse 3 freezes the gap counter.
        do_reset(6);
        run_n(48, p);
        check("dis_pre_pulses", p, 3);
        dis = 1'b1;
        run_n(100, p);
        check("dis_hold_pulses", p, 0);
        dis = 1'b0;
        run_lock(300, p, f, l, lk);
        check("dis_post_pulses", p, 3);
        check("dis_p4", f, 16);
        check("dis_lock", lk, 112);
        check("dis_slips", int'(pcs_slips), 6);

        // Overcorrection with target 1.
        do_reset(1);
        run_lock(300, p, f, l, lk);
        check("ovr_lock", lk, 80);
        for (int i = 0; i < 3; i++) pma_slip(fk, rk);
        check("ovr_ui", int'(pma_ui), 6);
        check("ovr_flag", int'(over), 1);
        check("ovr_keep_lock", int'(lock), 1);
        resync8();
        run_lock(200, p, f, l, lk);
        check("ovr_re_pulses", p, 0);
        check("ovr_re_lock", lk, 64);
        check("ovr_sticky", int'(over), 1);

        // Reset during PWAIT aborts and reloads the target.
        do_reset(5);
        run_n(10, p);
        slip_pma = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check("mid_pwait", int'(rdy), 0);
        check("mid_ui", int'(pma_ui), 2);
        rst_n = 1'b0;
        ctl_slip_target = 7'd3;
        tick();
        check("mid_rdy", int'(rdy), 1);
        check("mid_lock", int'(lock), 0);
        check("mid_stats", int'(pcs_slips) + int'(pma_ui) + int'(over), 0);
        slip_pma = 1'b0;
        tick();
        rst_n = 1'b1;
        ctl_slip_target = 7'd9;
        run_lock(300, p, f, l, lk);
        check("mid_pulses", p, 3);
        check("mid_relock", lk, 112);
        check("mid_rdy_idle", int'(rdy), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
